// File: rtl/vga_mem_arbiter_if.sv
// Processor, VGA scan-out and frame-RAM signal bundle for vga_mem_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface vga_mem_arbiter_if #(
  parameter int RAM_AW = 16,
  parameter int DATA_W = 32
);
  logic              proc_req;
  logic              proc_we;
  logic [31:0]       proc_addr;
  logic [DATA_W-1:0] proc_wdata;
  logic [DATA_W-1:0] proc_rdata;
  logic              proc_stall;

  logic              vga_req;
  logic [RAM_AW-1:0] vga_addr;
  logic              vga_gnt;
  logic              vga_valid;
  logic [DATA_W-1:0] vga_rdata;

  logic              ram_en;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  proc_req, proc_we, proc_addr, proc_wdata,
    output proc_rdata, proc_stall,
    input  vga_req, vga_addr,
    output vga_gnt, vga_valid, vga_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output proc_req, proc_we, proc_addr, proc_wdata,
    input  proc_rdata, proc_stall,
    output vga_req, vga_addr,
    input  vga_gnt, vga_valid, vga_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/vga_mem_arbiter.sv
// Single-port VGA frame RAM arbiter: VGA scan-out has priority,
// the processor wins after MAX_WAIT consecutive lost cycles.
module vga_mem_arbiter #(
  parameter int          RAM_AW   = 16,
  parameter int          DATA_W   = 32,
  parameter logic [31:0] VGA_BASE = 32'h0010_0000,
  parameter int          MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  vga_mem_arbiter_if.slave bus
);

  localparam int            WW   = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

  typedef enum logic {
    IDLE,
    PRD
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_VGA,
    OWN_PROC
  } own_e;

  state_e            state_q, state_d;
  own_e              own_q, own_d;
  logic [WW-1:0]     wait_q, wait_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic [DATA_W-1:0] vrdata_q, vrdata_d;

  logic              hit;
  logic              elig;
  logic              starve;
  logic              proc_gnt;
  logic              vga_gnt;
  logic [RAM_AW-1:0] p_addr;
  logic              unused_byte_sel;

  assign hit = bus.proc_req &&
    (bus.proc_addr[31:RAM_AW+2] == VGA_BASE[31:RAM_AW+2]);
  assign p_addr = bus.proc_addr[RAM_AW+1:2];
  assign unused_byte_sel = ^bus.proc_addr[1:0];

  // A read in its data cycle must not be issued a second time.
  assign elig   = hit && (state_q != PRD);
  assign starve = elig && (wait_q == WMAX);

  always_comb begin
    state_d       = IDLE;
    own_d         = OWN_NONE;
    wait_d        = '0;
    proc_gnt      = 1'b0;
    vga_gnt       = 1'b0;
    bus.ram_en    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    bus.proc_stall = 1'b0;

    priority case (1'b1)
      starve:      proc_gnt = 1'b1;
      bus.vga_req: vga_gnt  = 1'b1;
      elig:        proc_gnt = 1'b1;
      default:     ;
    endcase

    if (elig && !proc_gnt) begin
      bus.proc_stall = 1'b1;
      wait_d = (wait_q == WMAX) ? wait_q : wait_q + 1'b1;
    end

    if (proc_gnt) begin
      bus.ram_en   = 1'b1;
      bus.ram_we   = bus.proc_we;
      bus.ram_addr = p_addr;
      if (bus.proc_we) begin
        bus.ram_wdata = bus.proc_wdata;
      end else begin
        bus.proc_stall = 1'b1;
        state_d = PRD;
        own_d   = OWN_PROC;
      end
    end else if (vga_gnt) begin
      bus.ram_en   = 1'b1;
      bus.ram_addr = bus.vga_addr;
      own_d        = OWN_VGA;
    end
  end

  // Read data is steered by the owner of last cycle's access.
  assign prdata_d = (own_q == OWN_PROC) ? bus.ram_rdata : prdata_q;
  assign vrdata_d = (own_q == OWN_VGA)  ? bus.ram_rdata : vrdata_q;

  assign bus.vga_gnt    = vga_gnt;
  assign bus.vga_valid  = (own_q == OWN_VGA);
  assign bus.vga_rdata  = vrdata_d;
  assign bus.proc_rdata = prdata_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      own_q    <= OWN_NONE;
      wait_q   <= '0;
      prdata_q <= '0;
      vrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      own_q    <= own_d;
      wait_q   <= wait_d;
      prdata_q <= prdata_d;
      vrdata_q <= vrdata_d;
    end
  end

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Bench for vga_mem_arbiter: directed scenarios with literal expectations
// plus randomized traffic checked each cycle against a behavioural model.
module tb_vga_mem_arbiter;

  localparam int          AW   = 16;
  localparam int          DW   = 32;
  localparam int          MW   = 4;
  localparam logic [31:0] BASE = 32'h0010_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vga_mem_arbiter_if #(.RAM_AW(AW), .DATA_W(DW)) bus();

  vga_mem_arbiter #(
    .RAM_AW(AW), .DATA_W(DW), .VGA_BASE(BASE), .MAX_WAIT(MW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Frame RAM: one-cycle synchronous read
  logic [31:0] mem [0:65535];
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
    bus.ram_rdata = 32'h0;
  end
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      else bus.ram_rdata <= mem[bus.ram_addr];
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk1(string nm, logic act, logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: shadow memory plus pending-return bookkeeping
  logic [31:0] smem [int];
  int          mwait = 0;
  bit          m_prd = 0, m_vpend = 0;
  logic [31:0] m_pexp = 0, m_vexp = 0, m_lastp = 0, m_lastv = 0;
  bit          m_pdone = 0, m_vwin = 0;

  function automatic logic [31:0] rd(int a);
    return smem.exists(a) ? smem[a] : 32'h0;
  endfunction

  bit   hit, elig, starve, pwin, vwin;
  int   pa;
  always @(negedge clk) begin
    if (!rst) begin
      chk1("rst_vga_gnt", bus.vga_gnt, 1'b0);
      chk1("rst_vga_valid", bus.vga_valid, 1'b0);
      chk1("rst_proc_stall", bus.proc_stall, 1'b0);
      chk1("rst_ram_en", bus.ram_en, 1'b0);
      chk1("rst_ram_we", bus.ram_we, 1'b0);
      chk32("rst_ram_addr", 32'(bus.ram_addr), 32'h0);
      chk32("rst_ram_wdata", bus.ram_wdata, 32'h0);
      chk32("rst_proc_rdata", bus.proc_rdata, 32'h0);
      chk32("rst_vga_rdata", bus.vga_rdata, 32'h0);
      mwait = 0; m_prd = 0; m_vpend = 0;
      m_lastp = 0; m_lastv = 0; m_pdone = 0; m_vwin = 0;
    end else begin
      hit    = bus.proc_req && ((bus.proc_addr >> 18) == (BASE >> 18));
      elig   = hit && !m_prd;
      starve = elig && (mwait >= MW);
      pwin   = elig && (starve || !bus.vga_req);
      vwin   = bus.vga_req && !starve;
      pa     = int'(bus.proc_addr[17:2]);

      chk1("vga_gnt", bus.vga_gnt, vwin);
      chk1("ram_en", bus.ram_en, pwin || vwin);
      chk1("ram_we", bus.ram_we, pwin && bus.proc_we);
      if (pwin) chk32("ram_addr_p", 32'(bus.ram_addr), 32'(pa));
      else if (vwin) chk32("ram_addr_v", 32'(bus.ram_addr), 32'(bus.vga_addr));
      if (pwin && bus.proc_we) chk32("ram_wdata", bus.ram_wdata, bus.proc_wdata);
      chk1("proc_stall", bus.proc_stall,
           (elig && !pwin) || (pwin && !bus.proc_we));
      chk1("vga_valid", bus.vga_valid, m_vpend);
      chk32("vga_rdata", bus.vga_rdata, m_vpend ? m_vexp : m_lastv);
      chk32("proc_rdata", bus.proc_rdata, m_prd ? m_pexp : m_lastp);

      if (m_prd) m_lastp = m_pexp;
      if (m_vpend) m_lastv = m_vexp;
      m_pdone = m_prd || (pwin && bus.proc_we) || (bus.proc_req && !hit);
      m_vwin  = vwin;
      m_prd   = pwin && !bus.proc_we;
      m_pexp  = rd(pa);
      m_vpend = vwin;
      m_vexp  = rd(int'(bus.vga_addr));
      if (pwin && bus.proc_we) smem[pa] = bus.proc_wdata;
      mwait = (elig && !pwin) ? ((mwait < MW) ? mwait + 1 : MW) : 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.proc_req = 1'b0; bus.proc_we = 1'b0;
    bus.proc_addr = 32'h0; bus.proc_wdata = 32'h0;
    bus.vga_req = 1'b0; bus.vga_addr = '0;
  endtask

  bit pact, vact;
  int va;

  initial begin
    idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("init_ram_en", bus.ram_en, 1'b0);
    step(); rst = 1'b1;

    // non-hit read
    bus.proc_req = 1'b1; bus.proc_we = 1'b0; bus.proc_addr = 32'h0000_0100;
    @(negedge clk);
    chk1("nohit_stall", bus.proc_stall, 1'b0);
    chk1("nohit_en", bus.ram_en, 1'b0);

    // uncontended write
    step();
    bus.proc_we = 1'b1; bus.proc_addr = 32'h0010_0008;
    bus.proc_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk32("wr_addr", 32'(bus.ram_addr), 32'h2);
    chk1("wr_we", bus.ram_we, 1'b1);
    chk1("wr_stall", bus.proc_stall, 1'b0);

    // read back: one stall cycle, data in second cycle
    step(); bus.proc_we = 1'b0;
    @(negedge clk);
    chk1("rd0_stall", bus.proc_stall, 1'b1);
    chk1("rd0_en", bus.ram_en, 1'b1);
    step();
    @(negedge clk);
    chk1("rd1_stall", bus.proc_stall, 1'b0);
    chk32("rd1_data", bus.proc_rdata, 32'hDEAD_BEEF);
    chk1("rd1_no_reissue", bus.ram_en, 1'b0);
    step(); idle();

    // starvation limit under continuous VGA traffic
    va = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      bus.vga_req = 1'b1; bus.vga_addr = AW'(va);
      bus.proc_req = (c <= 4); bus.proc_we = 1'b1;
      bus.proc_addr = 32'h0010_0010; bus.proc_wdata = 32'h1234_5678;
      @(negedge clk);
      chk1("stv_gnt", bus.vga_gnt, c != 4);
      chk1("stv_stall", bus.proc_stall, c < 4);
      chk1("stv_valid", bus.vga_valid, (c >= 1) && (c != 5));
      if (c == 4) chk1("stv_pwe", bus.ram_we, 1'b1);
      if (c != 4) va++;
    end

    // processor data return and VGA grant in the same cycle
    step(); idle();
    bus.proc_req = 1'b1; bus.proc_addr = 32'h0010_0008;
    step();
    bus.vga_req = 1'b1; bus.vga_addr = AW'(4);
    @(negedge clk);
    chk1("prd_vgnt", bus.vga_gnt, 1'b1);
    chk1("prd_stall", bus.proc_stall, 1'b0);
    chk32("prd_pdata", bus.proc_rdata, 32'hDEAD_BEEF);
    chk32("prd_raddr", 32'(bus.ram_addr), 32'h4);
    step(); idle();
    @(negedge clk);
    chk1("prd_vvalid", bus.vga_valid, 1'b1);
    chk32("prd_vdata", bus.vga_rdata, 32'h1234_5678);

    // reset while a VGA read is in flight
    step(); bus.vga_req = 1'b1; bus.vga_addr = AW'(2);
    @(negedge clk);
    chk1("rsv_gnt", bus.vga_gnt, 1'b1);
    step(); rst = 1'b0; idle();
    @(negedge clk);
    chk1("rsv_valid0", bus.vga_valid, 1'b0);
    step(); rst = 1'b1;
    @(negedge clk);
    chk1("rsv_valid1", bus.vga_valid, 1'b0);
    step(); bus.vga_req = 1'b1; bus.vga_addr = AW'(2);
    @(negedge clk);
    chk1("rsv_gnt2", bus.vga_gnt, 1'b1);
    step(); idle();
    @(negedge clk);
    chk1("rsv_valid2", bus.vga_valid, 1'b1);
    chk32("rsv_data", bus.vga_rdata, 32'hDEAD_BEEF);

    // randomized traffic, requests held until the model says done
    pact = 0; vact = 0;
    repeat (3000) begin
      step();
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b0; pact = 0; vact = 0; idle();
      end else begin
        rst = 1'b1;
        if (pact && m_pdone) pact = 0;
        if (vact && m_vwin) vact = 0;
        if (!pact && $urandom_range(0, 2) == 0) begin
          pact = 1;
          bus.proc_we = 1'($urandom_range(0, 1));
          bus.proc_wdata = $urandom;
          if ($urandom_range(0, 4) != 0)
            bus.proc_addr = BASE | (32'($urandom_range(0, 15)) << 2)
                          | 32'($urandom_range(0, 3));
          else
            bus.proc_addr = $urandom & 32'h000F_FFFF;
        end
        bus.proc_req = pact;
        if (!vact && $urandom_range(0, 3) != 0) begin
          vact = 1;
          bus.vga_addr = AW'($urandom_range(0, 15));
        end
        bus.vga_req = vact;
      end
    end

    step(); idle(); rst = 1'b1;
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
